regif_reg_bank: RTL and testbench

REGIF_REG_BANK -- requirements
Module: regif_reg_bank

---
 rtl/regif_pkg.sv | 22 ++
 rtl/regif_reg_cell.sv | 66 ++++++
 rtl/regif_reg_bank.sv | 118 +++++++++++
 tb/tb_regif_reg_bank.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regif_pkg.sv
// Shared types and constants for the register-interface bank.
package regif_pkg;

    localparam int unsigned REGIF_ADDR_W = 14;
    localparam int unsigned REGIF_BASE_W = 7;
    localparam int unsigned REGIF_IDX_W  = 7;

    // Per-register access mode; encoding matches the 2-bit REG_MODE fields.
    typedef enum logic [1:0] {
        ModeRw    = 2'd0,
        ModeRo    = 2'd1,
        ModeW1c   = 2'd2,
        ModePulse = 2'd3
    } regif_mode_e;

    // True when the upper address bits select the bank at base.
    function automatic logic regif_addr_hit(logic [REGIF_ADDR_W-1:0] addr,
                                            logic [REGIF_BASE_W-1:0] base);
        return addr[REGIF_ADDR_W-1 -: REGIF_BASE_W] == base;
    endfunction

endpackage

// File: rtl/regif_reg_cell.sv
// One register of the bank: storage plus the mode-specific update and read view.
module regif_reg_cell
    import regif_pkg::*;
#(
    parameter int unsigned       DATA_W    = 32,
    parameter logic [1:0]        MODE      = 2'd0,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              AXI_ACLK,
    input  logic              axi_rstn,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] wmask,
    input  logic [DATA_W-1:0] hw_val,
    input  logic [DATA_W-1:0] hw_set,
    output logic [DATA_W-1:0] reg_q,
    output logic [DATA_W-1:0] rd_val,
    output logic              irq_src
);

    localparam regif_mode_e Mode = regif_mode_e'(MODE);
    // Pulse registers always come out of reset idle.
    localparam logic [DATA_W-1:0] ResetQ = (Mode == ModePulse) ? '0 : RESET_VAL;

    logic [DATA_W-1:0] q_q;
    logic [DATA_W-1:0] q_d;
    logic [DATA_W-1:0] wr_bits;

    assign wr_bits = wr_en ? (wdata & wmask) : '0;

    // Next-state per access mode; unstrobed bytes are never touched.
    always_comb begin
        q_d = q_q;
        case (Mode)
            ModeRw:    if (wr_en) q_d = (q_q & ~wmask) | wr_bits;
            ModeRo:    q_d = q_q;
            // Hardware set wins over a simultaneous software clear.
            ModeW1c:   q_d = (q_q & ~wr_bits) | hw_set;
            ModePulse: q_d = wr_bits;
            default:   q_d = q_q;
        endcase
    end

    // Register storage.
    always_ff @(posedge AXI_ACLK or negedge axi_rstn) begin
        if (!axi_rstn) begin
            q_q <= ResetQ;
        end else begin
            q_q <= q_d;
        end
    end

    // Value a software read observes.
    always_comb begin
        rd_val = q_q;
        case (Mode)
            ModeRo:    rd_val = hw_val;
            ModePulse: rd_val = '0;
            default:   rd_val = q_q;
        endcase
    end

    assign reg_q   = q_q;
    assign irq_src = (Mode == ModeW1c) && (|q_q);

endmodule

// File: rtl/regif_reg_bank.sv
// Register bank: address decode, per-register cells and one-cycle ack pipeline.
module regif_reg_bank
    import regif_pkg::*;
#(
    parameter logic [REGIF_BASE_W-1:0]    BASE_ADDRESS = 7'h00,
    parameter int unsigned                NUM_REGS     = 8,
    parameter int unsigned                DATA_W       = 32,
    parameter logic [2*NUM_REGS-1:0]      REG_MODE     = '0,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL    = '0
) (
    input  logic                         AXI_ACLK,
    input  logic                         axi_rstn,
    input  logic                         axi_wreq,
    input  logic [REGIF_ADDR_W-1:0]      axi_waddr,
    input  logic [DATA_W-1:0]            axi_wdata,
    input  logic [DATA_W/8-1:0]          axi_wstrb,
    output logic                         axi_wack,
    output logic                         axi_werr,
    input  logic                         axi_rreq,
    input  logic [REGIF_ADDR_W-1:0]      axi_raddr,
    output logic [DATA_W-1:0]            axi_rdata,
    output logic                         axi_rack,
    output logic                         axi_rerr,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_val,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_set,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic                         irq
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam logic [REGIF_IDX_W:0] NumRegsW = (REGIF_IDX_W + 1)'(NUM_REGS);

    logic [REGIF_IDX_W-1:0] widx;
    logic [REGIF_IDX_W-1:0] ridx;
    logic                   wr_hit;
    logic                   rd_hit;
    logic                   widx_ok;
    logic                   ridx_ok;
    logic [DATA_W-1:0]      wmask;
    logic [DATA_W-1:0]      rd_view [NUM_REGS];
    logic [DATA_W-1:0]      rd_sel;
    logic [NUM_REGS-1:0]    irq_src;

    logic              wack_q;
    logic              werr_q;
    logic              rack_q;
    logic              rerr_q;
    logic [DATA_W-1:0] rdata_q;
    logic              irq_q;

    assign widx    = axi_waddr[REGIF_IDX_W-1:0];
    assign ridx    = axi_raddr[REGIF_IDX_W-1:0];
    assign wr_hit  = axi_wreq && regif_addr_hit(axi_waddr, BASE_ADDRESS);
    assign rd_hit  = axi_rreq && regif_addr_hit(axi_raddr, BASE_ADDRESS);
    assign widx_ok = {1'b0, widx} < NumRegsW;
    assign ridx_ok = {1'b0, ridx} < NumRegsW;

    // Byte strobes expanded to a bit mask shared by all cells.
    for (genvar b = 0; b < STRB_W; b++) begin : g_mask
        assign wmask[8*b +: 8] = {8{axi_wstrb[b]}};
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        regif_reg_cell #(
            .DATA_W    (DATA_W),
            .MODE      (REG_MODE[2*i +: 2]),
            .RESET_VAL (RESET_VAL[i*DATA_W +: DATA_W])
        ) u_cell (
            .AXI_ACLK (AXI_ACLK),
            .axi_rstn (axi_rstn),
            .wr_en    (wr_hit && widx_ok && (widx == REGIF_IDX_W'(i))),
            .wdata    (axi_wdata),
            .wmask    (wmask),
            .hw_val   (hw_val[i*DATA_W +: DATA_W]),
            .hw_set   (hw_set[i*DATA_W +: DATA_W]),
            .reg_q    (reg_q[i*DATA_W +: DATA_W]),
            .rd_val   (rd_view[i]),
            .irq_src  (irq_src[i])
        );
    end

    // Read mux over the pre-write register views.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ridx == REGIF_IDX_W'(i)) begin
                rd_sel = rd_view[i];
            end
        end
    end

    // Ack/response pipeline; rdata is forced to zero outside an ack so buses can OR-merge.
    always_ff @(posedge AXI_ACLK or negedge axi_rstn) begin
        if (!axi_rstn) begin
            wack_q  <= 1'b0;
            werr_q  <= 1'b0;
            rack_q  <= 1'b0;
            rerr_q  <= 1'b0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            wack_q  <= wr_hit;
            werr_q  <= wr_hit && !widx_ok;
            rack_q  <= rd_hit;
            rerr_q  <= rd_hit && !ridx_ok;
            rdata_q <= (rd_hit && ridx_ok) ? rd_sel : '0;
            irq_q   <= |irq_src;
        end
    end

    assign axi_wack  = wack_q;
    assign axi_werr  = werr_q;
    assign axi_rack  = rack_q;
    assign axi_rerr  = rerr_q;
    assign axi_rdata = rdata_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_regif_reg_bank.sv
// Self-checking bench for regif_reg_bank: directed cases plus randomized traffic
// compared every cycle against a behavioural model.
module tb_regif_reg_bank;

    localparam int NR = 8;
    localparam int DW = 32;
    localparam logic [6:0] BASE = 7'h11;
    // Modes reg7..reg0: RO, W1C, RW, RO, PULSE, W1C, RW, RW
    localparam logic [2*NR-1:0] MODES = {2'd1, 2'd2, 2'd0, 2'd1, 2'd3, 2'd2, 2'd0, 2'd0};
    localparam logic [NR*DW-1:0] RV = {32'h00000007, 32'h00000000, 32'h12345678, 32'h5a5a0000,
                                       32'h00000000, 32'h00000000, 32'hc0decafe, 32'h000000a5};

    logic                 AXI_ACLK = 1'b0;
    logic                 axi_rstn;
    logic                 axi_wreq;
    logic [13:0]          axi_waddr;
    logic [DW-1:0]        axi_wdata;
    logic [DW/8-1:0]      axi_wstrb;
    logic                 axi_wack;
    logic                 axi_werr;
    logic                 axi_rreq;
    logic [13:0]          axi_raddr;
    logic [DW-1:0]        axi_rdata;
    logic                 axi_rack;
    logic                 axi_rerr;
    logic [NR*DW-1:0]     hw_val;
    logic [NR*DW-1:0]     hw_set;
    logic [NR*DW-1:0]     reg_q;
    logic                 irq;

    int n_checks = 0;
    int n_pass   = 0;
    logic cmp_en = 1'b0;

    always #5 AXI_ACLK = ~AXI_ACLK;

    regif_reg_bank #(
        .BASE_ADDRESS (BASE),
        .NUM_REGS     (NR),
        .DATA_W       (DW),
        .REG_MODE     (MODES),
        .RESET_VAL    (RV)
    ) dut (
        .AXI_ACLK  (AXI_ACLK),
        .axi_rstn  (axi_rstn),
        .axi_wreq  (axi_wreq),
        .axi_waddr (axi_waddr),
        .axi_wdata (axi_wdata),
        .axi_wstrb (axi_wstrb),
        .axi_wack  (axi_wack),
        .axi_werr  (axi_werr),
        .axi_rreq  (axi_rreq),
        .axi_raddr (axi_raddr),
        .axi_rdata (axi_rdata),
        .axi_rack  (axi_rack),
        .axi_rerr  (axi_rerr),
        .hw_val    (hw_val),
        .hw_set    (hw_set),
        .reg_q     (reg_q),
        .irq       (irq)
    );

    task automatic check(input string name, input logic [NR*DW-1:0] act,
                         input logic [NR*DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_q [NR];
    logic          exp_wack, exp_werr, exp_rack, exp_rerr, exp_irq;
    logic [DW-1:0] exp_rdata;
    logic [DW-1:0] nq;
    logic [1:0]    md;
    int            wi, ri;
    logic          whit, rhit;

    always @(posedge AXI_ACLK or negedge axi_rstn) begin
        if (!axi_rstn) begin
            for (int i = 0; i < NR; i++) begin
                m_q[i] = (MODES[2*i +: 2] == 2'd3) ? 32'h0 : RV[DW*i +: DW];
            end
            exp_wack  = 1'b0;
            exp_werr  = 1'b0;
            exp_rack  = 1'b0;
            exp_rerr  = 1'b0;
            exp_rdata = '0;
            exp_irq   = 1'b0;
        end else begin
            whit = axi_wreq && (axi_waddr[13:7] == BASE);
            rhit = axi_rreq && (axi_raddr[13:7] == BASE);
            wi   = int'(axi_waddr[6:0]);
            ri   = int'(axi_raddr[6:0]);
            exp_wack  = whit;
            exp_werr  = whit && (wi >= NR);
            exp_rack  = rhit;
            exp_rerr  = rhit && (ri >= NR);
            // Reads see the value before this cycle's write.
            exp_rdata = '0;
            if (rhit && ri < NR) begin
                case (MODES[2*ri +: 2])
                    2'd1:    exp_rdata = hw_val[DW*ri +: DW];
                    2'd3:    exp_rdata = '0;
                    default: exp_rdata = m_q[ri];
                endcase
            end
            exp_irq = 1'b0;
            for (int i = 0; i < NR; i++) begin
                if (MODES[2*i +: 2] == 2'd2 && m_q[i] != 0) exp_irq = 1'b1;
            end
            for (int i = 0; i < NR; i++) begin
                md = MODES[2*i +: 2];
                nq = (md == 2'd3) ? 32'h0 : m_q[i];
                for (int b = 0; b < DW/8; b++) begin
                    if (whit && wi == i && axi_wstrb[b]) begin
                        case (md)
                            2'd0, 2'd3: nq[8*b +: 8] = axi_wdata[8*b +: 8];
                            2'd2:       nq[8*b +: 8] = nq[8*b +: 8] & ~axi_wdata[8*b +: 8];
                            default:    ;
                        endcase
                    end
                end
                if (md == 2'd2) nq = nq | hw_set[DW*i +: DW];
                m_q[i] = nq;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [NR*DW-1:0] cmp_pk;

    always @(negedge AXI_ACLK) begin
        if (cmp_en) begin
            for (int i = 0; i < NR; i++) cmp_pk[DW*i +: DW] = m_q[i];
            check("wack",  (NR*DW)'(axi_wack),  (NR*DW)'(exp_wack));
            check("werr",  (NR*DW)'(axi_werr),  (NR*DW)'(exp_werr));
            check("rack",  (NR*DW)'(axi_rack),  (NR*DW)'(exp_rack));
            check("rerr",  (NR*DW)'(axi_rerr),  (NR*DW)'(exp_rerr));
            check("rdata", (NR*DW)'(axi_rdata), (NR*DW)'(exp_rdata));
            check("irq",   (NR*DW)'(irq),       (NR*DW)'(exp_irq));
            check("reg_q", reg_q, cmp_pk);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input logic [13:0] a, input logic [DW-1:0] d, input logic [3:0] s);
        axi_wreq  = 1'b1;
        axi_waddr = a;
        axi_wdata = d;
        axi_wstrb = s;
        @(negedge AXI_ACLK);
        axi_wreq  = 1'b0;
    endtask

    task automatic rd(input logic [13:0] a);
        axi_rreq  = 1'b1;
        axi_raddr = a;
        @(negedge AXI_ACLK);
        axi_rreq  = 1'b0;
    endtask

    function automatic logic [13:0] rand_addr();
        logic [6:0] base;
        logic [6:0] idx;
        base = ($urandom_range(0, 7) == 0) ? 7'($urandom) : BASE;
        idx  = 7'($urandom_range(0, 10));
        return {base, idx};
    endfunction

    initial begin
        axi_rstn  = 1'b0;
        axi_wreq  = 1'b0;
        axi_rreq  = 1'b0;
        axi_waddr = '0;
        axi_raddr = '0;
        axi_wdata = '0;
        axi_wstrb = '0;
        hw_set    = '0;
        hw_val    = {32'h70707070, 32'h0, 32'h0, 32'hbeef0004, 32'h0, 32'h0, 32'h0, 32'h0};
        cmp_en    = 1'b1;
        repeat (3) @(negedge AXI_ACLK);
        axi_rstn = 1'b1;
        @(negedge AXI_ACLK);
        check("reset_regs",  reg_q, RV);
        check("reset_irq",   (NR*DW)'(irq), '0);
        check("reset_rdata", (NR*DW)'(axi_rdata), '0);

        // Basic write/read at base 0x11, register 0.
        wr(14'h0880, 32'hdeadbeef, 4'hF);
        check("wr0_wack", (NR*DW)'({axi_wack, axi_werr}), (NR*DW)'(2'b10));
        rd(14'h0880);
        check("rd0_rack",  (NR*DW)'({axi_rack, axi_rerr}), (NR*DW)'(2'b10));
        check("rd0_rdata", (NR*DW)'(axi_rdata), (NR*DW)'(32'hdeadbeef));
        @(negedge AXI_ACLK);
        check("rd0_idle", (NR*DW)'({axi_rack, axi_rdata}), '0);

        // Byte-strobed write to RW register 1.
        wr(14'h0881, 32'h11223344, 4'b0101);
        rd(14'h0881);
        check("rd1_strb", (NR*DW)'(axi_rdata), (NR*DW)'(32'hc022ca44));

        // W1C register 2.
        hw_set[2*DW + 3] = 1'b1;
        @(negedge AXI_ACLK);
        hw_set = '0;
        check("w1c_set", (NR*DW)'(reg_q[2*DW +: DW]), (NR*DW)'(32'h8));
        @(negedge AXI_ACLK);
        check("w1c_irq1", (NR*DW)'(irq), (NR*DW)'(1'b1));
        wr(14'h0882, 32'h8, 4'hF);
        check("w1c_clr", (NR*DW)'(reg_q[2*DW +: DW]), '0);
        rd(14'h0882);
        check("w1c_rd0",  (NR*DW)'(axi_rdata), '0);
        check("w1c_irq0", (NR*DW)'(irq), '0);
        hw_set[2*DW + 3] = 1'b1;
        wr(14'h0882, 32'h8, 4'hF);
        hw_set = '0;
        check("w1c_setwins", (NR*DW)'(reg_q[2*DW +: DW]), (NR*DW)'(32'h8));
        wr(14'h0882, 32'h8, 4'hF);

        // PULSE register 3.
        wr(14'h0883, 32'h1, 4'hF);
        check("pulse_hi", (NR*DW)'(reg_q[3*DW +: DW]), (NR*DW)'(32'h1));
        rd(14'h0883);
        check("pulse_lo", (NR*DW)'(reg_q[3*DW +: DW]), '0);
        check("pulse_rd", (NR*DW)'({axi_rack, axi_rdata}), (NR*DW)'({1'b1, 32'h0}));

        // RO register 4: write ignored without error, reads hw_val.
        wr(14'h0884, 32'hffffffff, 4'hF);
        check("ro_wack", (NR*DW)'({axi_wack, axi_werr}), (NR*DW)'(2'b10));
        check("ro_keep", (NR*DW)'(reg_q[4*DW +: DW]), (NR*DW)'(32'h5a5a0000));
        rd(14'h0884);
        check("ro_rd", (NR*DW)'(axi_rdata), (NR*DW)'(32'hbeef0004));

        // Out-of-range index.
        rd(14'h0889);
        check("oor_rd", (NR*DW)'({axi_rack, axi_rerr, axi_rdata}), (NR*DW)'({2'b11, 32'h0}));
        wr(14'h088a, 32'h1234, 4'hF);
        check("oor_wr", (NR*DW)'({axi_wack, axi_werr}), (NR*DW)'(2'b11));

        // Other base: no ack for five cycles.
        wr(14'h0005, 32'h00012345, 4'hF);
        for (int k = 0; k < 5; k++) begin
            check("nobase_wack", (NR*DW)'(axi_wack), '0);
            @(negedge AXI_ACLK);
        end

        // Simultaneous read and write of register 5 returns the old value.
        axi_rreq  = 1'b1;
        axi_raddr = 14'h0885;
        wr(14'h0885, 32'haaaa5555, 4'hF);
        axi_rreq  = 1'b0;
        check("rw_same_rd", (NR*DW)'(axi_rdata), (NR*DW)'(32'h12345678));
        check("rw_same_q",  (NR*DW)'(reg_q[5*DW +: DW]), (NR*DW)'(32'haaaa5555));

        // Back-to-back writes.
        axi_wreq = 1'b1; axi_waddr = 14'h0880; axi_wdata = 32'h1; axi_wstrb = 4'hF;
        @(negedge AXI_ACLK);
        check("b2b_ack1", (NR*DW)'(axi_wack), (NR*DW)'(1'b1));
        axi_waddr = 14'h0881; axi_wdata = 32'h2;
        @(negedge AXI_ACLK);
        axi_wreq = 1'b0;
        check("b2b_ack2", (NR*DW)'(axi_wack), (NR*DW)'(1'b1));
        check("b2b_q", (NR*DW)'(reg_q[2*DW-1:0]), (NR*DW)'(64'h00000002_00000001));

        // Reset while a write ack is pending.
        axi_wreq = 1'b1; axi_waddr = 14'h0885; axi_wdata = 32'hfeedface; axi_wstrb = 4'hF;
        @(posedge AXI_ACLK);
        #1;
        axi_rstn = 1'b0;
        axi_wreq = 1'b0;
        @(negedge AXI_ACLK);
        check("rst_nowack", (NR*DW)'(axi_wack), '0);
        @(negedge AXI_ACLK);
        axi_rstn = 1'b1;
        @(negedge AXI_ACLK);
        check("rst_nowack2", (NR*DW)'(axi_wack), '0);
        check("rst_regs", reg_q, RV);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            axi_wreq  = 1'($urandom_range(0, 1));
            axi_rreq  = 1'($urandom_range(0, 1));
            axi_waddr = rand_addr();
            axi_raddr = ($urandom_range(0, 3) == 0) ? axi_waddr : rand_addr();
            axi_wdata = $urandom;
            axi_wstrb = 4'($urandom);
            for (int i = 0; i < NR; i++) begin
                hw_set[DW*i +: DW] = $urandom & $urandom & $urandom & $urandom;
                hw_val[DW*i +: DW] = $urandom;
            end
            @(negedge AXI_ACLK);
        end
        axi_wreq = 1'b0;
        axi_rreq = 1'b0;
        hw_set   = '0;
        repeat (3) @(negedge AXI_ACLK);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
